seven_unpermute: RTL
====================

SEVEN_UNPERMUTE -- requirements
Module: seven_unpermute

Interface
REQ-001 SHALL have parameter QUERY_BASE, default 1: the q_val code that denotes permutation position 0; position p is coded as QUERY_BASE+p.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz), rising-edge only.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load  input  1  request to build a new table from the digit inputs.
REQ-005 SHALL have port d7  input  3  Lehmer digit for position 0, legal range 0..6.
REQ-006 SHALL have port d6  input  3  Lehmer digit for position 1, legal range 0..5.
REQ-007 SHALL have port d5  input  3  Lehmer digit for position 2, legal range 0..4.
REQ-008 SHALL have port d4  input  2  Lehmer digit for position 3, legal range 0..3.
REQ-009 SHALL have port d3  input  2  Lehmer digit for position 4, legal range 0..2.
REQ-010 SHALL have port d2  input  1  Lehmer digit for position 5, legal range 0..1.
REQ-011 SHALL have port busy  output  1  table build in progress.
REQ-012 SHALL have port table_valid  output  1  table complete; queries are answered.
REQ-013 SHALL have port load_err  output  1  last accepted load had an out-of-range digit.
REQ-014 SHALL have port q_valid  input  1  query strobe.
REQ-015 SHALL have port q_val  input  3  permuted value to invert.
REQ-016 SHALL have port r_valid  output  1  one-cycle response strobe.
REQ-017 SHALL have port r_val  output  3  recovered original value, range 0..6.
REQ-018 SHALL have port r_err  output  1  query rejected.

Function
REQ-019 SHALL implement FSM states IDLE, BUILD, READY; load is accepted on a rising edge only in IDLE or READY and is ignored in BUILD.
REQ-020 SHALL capture d7..d2 into registers on the acceptance edge, clear table_valid, clear load_err, and enter BUILD.
REQ-021 SHALL range-check the captured digits in the first BUILD cycle; if any digit is out of range, it SHALL set load_err, leave table_valid at 0, and return to IDLE on the next edge.
REQ-022 SHALL start the pool as the ascending list 0..6 and, on each of 7 consecutive BUILD edges p=0..6, remove pool entry at index dp (d7 for p=0 .. d2 for p=5, index 0 for p=6, with the remaining entries kept ascending) and store it as table[p].
REQ-023 SHALL, after the 7th BUILD edge, deassert busy, assert table_valid, and enter READY; busy is high exactly 7 cycles after acceptance.
REQ-024 SHALL sample q_valid on every rising edge and assert r_valid for exactly one cycle after each edge where q_valid=1 (latency 1, no backpressure, one response per cycle).
REQ-025 SHALL respond with r_err=0 and r_val=table[q_val-QUERY_BASE] when table_valid=1 before the edge and q_val-QUERY_BASE is in 0..6.
REQ-026 SHALL respond with r_err=1 and r_val=0 when table_valid=0 before the edge, including during BUILD, on the acceptance edge, and on the completion edge, or when the position is out of range.
REQ-027 SHALL hold r_val and r_err at their last values while r_valid=0.
REQ-028 SHALL invalidate the previous table on acceptance of a load in READY; the old contents are not queryable afterwards.
REQ-029 SHALL give the exact inverse of the team's Lehmer-digit permuter for identical digits: for value v, if the permuter outputs v at code QUERY_BASE+p, then a query of that code returns v.

Reset
REQ-030 SHALL, on rst=0 at any time including mid-BUILD, immediately enter IDLE and drive busy=0, table_valid=0, load_err=0, r_valid=0, r_val=0, r_err=0, and clear the table and digit registers.
REQ-031 SHALL accept no load and produce no response while rst=0; the first accepted load occurs on the first rising edge after rst returns to 1.

Verification
REQ-032 SHALL be verified with digits all 0, load, then queries 1..7 -> busy for 7 cycles, then r_val 0,1,2,3,4,5,6.
REQ-033 SHALL be verified with d7..d2=6,5,4,3,2,1 -> queries 1..7 return 6,5,4,3,2,1,0.
REQ-034 SHALL be verified with d7..d2=3,0,2,1,2,0 -> table 3,0,4,2,6,1,5, so query 5 returns 6 and query 7 returns 5.
REQ-035 SHALL be verified with d6=6 -> load_err=1, table_valid stays 0, and a subsequent query returns r_err=1 with r_val=0.
REQ-036 SHALL be verified with rst pulsed low at BUILD cycle 4 -> outputs reset immediately; a query after release returns r_err=1; a reload then completes normally.
REQ-037 SHALL be verified with a query of 0 in READY, a query during BUILD, and a load asserted during BUILD -> r_err=1 for both queries, and the load is ignored with build timing unchanged.

Source files
------------

// File: rtl/seven_unpermute.sv
`timescale 1ns/1ps
// Builds a 7-entry permutation table from Lehmer digits, one position per cycle.
// Answers single-cycle inverse lookups: the code for position p returns table[p].
module seven_unpermute #(
  parameter int QUERY_BASE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] d7,
  input  logic [2:0] d6,
  input  logic [2:0] d5,
  input  logic [1:0] d4,
  input  logic [1:0] d3,
  input  logic       d2,
  output logic       busy,
  output logic       table_valid,
  output logic       load_err,
  input  logic       q_valid,
  input  logic [2:0] q_val,
  output logic       r_valid,
  output logic [2:0] r_val,
  output logic       r_err
);

  typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;

  state_t state, state_next;

  logic [2:0] dig7, dig6, dig5;
  logic [1:0] dig4, dig3;
  logic       dig2;
  logic [2:0] step;
  logic [2:0] pool [7];
  logic [2:0] tbl  [7];
  logic [2:0] idx;
  logic       accept, step_en, fail;
  logic signed [31:0] pos;
  logic       pos_ok;

  function automatic logic digits_ok(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c, input logic [1:0] e);
    return (a <= 3'd6) && (b <= 3'd5) && (c <= 3'd4) && (e <= 2'd2);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE, READY: begin
        if (load) begin
          accept     = 1'b1;
          state_next = BUILD;
        end
      end
      BUILD: begin
        if (step == 3'd0 && !digits_ok(dig7, dig6, dig5, dig3)) begin
          fail       = 1'b1;
          state_next = IDLE;
        end else begin
          step_en = 1'b1;
          if (step == 3'd6) state_next = READY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state == BUILD);
  assign table_valid = (state == READY);

  // Pool index removed at each build step; the last step takes the sole survivor.
  always_comb begin
    idx = 3'd0;
    case (step)
      3'd0: idx = dig7;
      3'd1: idx = dig6;
      3'd2: idx = dig5;
      3'd3: idx = {1'b0, dig4};
      3'd4: idx = {1'b0, dig3};
      3'd5: idx = {2'b00, dig2};
      default: idx = 3'd0;
    endcase
  end

  assign pos    = $signed({29'd0, q_val}) - QUERY_BASE;
  assign pos_ok = (pos >= 0) && (pos <= 6);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig7     <= '0;
      dig6     <= '0;
      dig5     <= '0;
      dig4     <= '0;
      dig3     <= '0;
      dig2     <= 1'b0;
      step     <= '0;
      load_err <= 1'b0;
      r_valid  <= 1'b0;
      r_val    <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        pool[i] <= '0;
        tbl[i]  <= '0;
      end
    end else begin
      if (accept) begin
        dig7     <= d7;
        dig6     <= d6;
        dig5     <= d5;
        dig4     <= d4;
        dig3     <= d3;
        dig2     <= d2;
        step     <= '0;
        load_err <= 1'b0;
        for (int i = 0; i < 7; i++) pool[i] <= 3'(i);
      end else if (fail) begin
        load_err <= 1'b1;
      end else if (step_en) begin
        // Remove pool[idx] and close the gap so the pool stays ascending.
        tbl[step] <= pool[idx];
        for (int i = 0; i < 6; i++)
          if (3'(i) >= idx) pool[i] <= pool[i+1];
        step <= step + 3'd1;
      end

      r_valid <= q_valid;
      if (q_valid) begin
        if (table_valid && !accept && pos_ok) begin
          r_val <= tbl[pos[2:0]];
          r_err <= 1'b0;
        end else begin
          r_val <= '0;
          r_err <= 1'b1;
        end
      end
    end
  end

endmodule
